handshaking_receiver: RTL and testbench
=======================================

Name: handshaking_receiver

Overview:
- Receiving end of the team's four-phase valid/ready handshake.
- Accepts words from a handshaking sender by raising data_ready while data_valid is high, then releases data_ready once the sender drops data_valid.
- Buffers accepted words in a small FIFO with show-ahead output, so downstream logic pops at its own pace.
- Back-pressures the sender by withholding data_ready when the FIFO is full.

Parameters:
- DATA_WIDTH, 8, width of the data word.
- FIFO_DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 0, flops on data_valid before the FSM; 0 (same-domain sender) or 2 (synchroniser); other values illegal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- data_in  input  DATA_WIDTH  word from sender; stable while data_valid=1.
- data_valid  input  1  sender request (four-phase REQ).
- data_ready  output  1  receiver acknowledge (four-phase ACK), registered.
- data_out  output  DATA_WIDTH  FIFO head word (show-ahead).
- out_valid  output  1  FIFO non-empty, registered.
- rd_en  input  1  downstream pop; honoured only when out_valid=1.
- fill_count  output  $clog2(FIFO_DEPTH)+1  entries currently held.

Behaviour:
- Reset (rst=0, asynchronous): data_ready=0, out_valid=0, fill_count=0, data_out=0, FSM=IDLE, read/write pointers=0, sync flops=0. All memory words clear to 0.
- v_s is data_valid after SYNC_STAGES flops; it equals data_valid when SYNC_STAGES=0.
- FSM IDLE:
  - If v_s=1 and fill_count<FIFO_DEPTH (registered count) at edge N: write data_in to the FIFO, set data_ready=1, go to ACK.
  - Otherwise stay in IDLE with data_ready=0.
- FSM ACK: data_ready holds 1. At the first edge where v_s=0: data_ready=0, go to IDLE.
- Each four-phase cycle writes exactly one word. A sender holding data_valid high in ACK is never captured twice.
- Acceptance latency:
  - SYNC_STAGES=0: data_ready rises after the edge that samples data_valid=1.
  - SYNC_STAGES=2: 2 extra cycles on both the rise and the fall of data_ready.
- Data capture: data_in is sampled on the same edge as the write (the edge at which v_s=1). With SYNC_STAGES=2, data_in is required stable from data_valid rise until data_ready rises.
- Full: while fill_count==FIFO_DEPTH, the FSM waits in IDLE with data_ready=0. A pop at edge N enables acceptance at edge N+1 at the earliest; no same-edge pop-and-accept when full.
- FIFO read:
  - If rd_en=1 and out_valid=1 at an edge, the read pointer advances.
  - data_out shows the new head after that edge. out_valid falls after that edge if the FIFO becomes empty.
  - rd_en while empty is ignored: no pointer, count or data change.
- Simultaneous write and pop at the same edge: both happen, fill_count unchanged, out_valid stays 1.
- Write into an empty FIFO: data_out and out_valid are valid after the write edge (1-cycle latency, no bubble).
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. fill_count is maintained separately and ranges 0..FIFO_DEPTH.
- Reset asserted mid-handshake: everything returns to reset values immediately, including dropping data_ready asynchronously and discarding FIFO contents. After release, a still-high data_valid is accepted as a new word.
- data_out is 0 whenever out_valid=0 after reset; otherwise it is the stale last word. Verification checks data_out only when out_valid=1.

Test Plan:
- Reset and single word: pulse rst low 20 ns. Send data_in=8'h5A via full four-phase handshake, SYNC_STAGES=0 -> data_ready=1 one edge after data_valid=1 and drops one edge after data_valid=0; out_valid=1, data_out=8'h5A, fill_count=1.
- Burst to full: send 8'h01..8'h05 with rd_en=0, FIFO_DEPTH=4 -> first four acknowledged, fill_count=4. Fifth data_valid sees data_ready=0 until one rd_en pop (data_out=8'h01), then 8'h05 is accepted on the following edge.
- Drain order: after the burst, hold rd_en=1 -> data_out sequence 8'h02,8'h03,8'h04,8'h05; out_valid falls after the last pop; an extra rd_en changes nothing, fill_count=0.
- Simultaneous pop and write: with fill_count=2, pop on the same edge as accepting 8'hA5 -> fill_count stays 2, head advances, 8'hA5 emerges last.
- Held request: keep data_valid=1 for 10 cycles with data_in=8'h3C -> exactly one write, fill_count increments by 1 only.
- Reset mid-handshake: assert rst while data_ready=1 and fill_count=3 -> data_ready, out_valid, fill_count go 0 without a clock edge. With data_valid still 1 after release, the word is re-accepted and fill_count=1.

Source files
------------

// File: rtl/handshaking_receiver_if.sv
// Four-phase valid/ready link between a handshaking sender and the receiver.
// The sender (master) drives the word and the request; the receiver (slave)
// answers with the acknowledge.
interface handshaking_receiver_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/handshaking_receiver.sv
// Receiving end of the four-phase valid/ready handshake.
// Accepted words land in a small show-ahead FIFO so downstream logic can pop
// at its own pace. The sender is held off by withholding data_ready while the
// FIFO is full. data_valid can optionally pass through a synchroniser
// (SYNC_STAGES = 2) when the sender lives in another clock domain; only 0 and
// 2 are meaningful settings.
module handshaking_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 0,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  handshaking_receiver_if.slave   hs,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    out_valid,
  input  logic                    rd_en,
  output logic [CW-1:0]           fill_count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  v_s;
  logic                  wr_en;
  logic                  rd_fire;
  logic                  data_ready_q;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign v_s = hs.data_valid;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the sender's request through the synchroniser chain.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= hs.data_valid;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign v_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Handshake state register; data_ready is registered and follows the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_ready_q <= (state_d == ACK);
    end
  end

  // Accept one word per request from IDLE when there is room; wait in ACK for the request to drop.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_s && (count_q < DEPTH_C)) begin
          wr_en   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!v_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_fire = rd_en && out_valid;
  assign count_d = count_q + CW'(wr_en) - CW'(rd_fire);

  // FIFO storage; cleared on reset so the head reads 0 until something is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= hs.data_in;
    end
  end

  // Pointers wrap naturally at FIFO_DEPTH; the count is kept separately to tell full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q   <= count_d;
      out_valid <= (count_d != '0);
    end
  end

  assign hs.data_ready = data_ready_q;
  assign data_out      = mem[rd_ptr];
  assign fill_count    = count_q;

endmodule

// File: tb/tb_handshaking_receiver.sv
// Directed bench for handshaking_receiver (DATA_WIDTH=8, FIFO_DEPTH=4, SYNC_STAGES=0).
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_handshaking_receiver;

  logic       clk;
  logic       rst;
  logic       rd_en;
  logic [7:0] data_out;
  logic       out_valid;
  logic [2:0] fill_count;

  int n_checks;
  int n_pass;

  handshaking_receiver_if #(.DATA_WIDTH(8)) hs_if ();

  handshaking_receiver #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .SYNC_STAGES(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hs        (hs_if.slave),
    .data_out  (data_out),
    .out_valid (out_valid),
    .rd_en     (rd_en),
    .fill_count(fill_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full four-phase transfer with bounded waits; ok=0 if either wait expires.
  task automatic send_word(input logic [7:0] d, output bit ok);
    int n;
    ok = 1'b1;
    hs_if.data_in    = d;
    hs_if.data_valid = 1'b1;
    n = 0;
    while (hs_if.data_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (hs_if.data_ready !== 1'b1) ok = 1'b0;
    hs_if.data_valid = 1'b0;
    n = 0;
    while (hs_if.data_ready !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    if (hs_if.data_ready !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst              = 1'b0;
    rd_en            = 1'b0;
    hs_if.data_valid = 1'b0;
    hs_if.data_in    = 8'h00;
    #10;
    n_checks++;
    if (hs_if.data_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", hs_if.data_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++;
    if (fill_count !== 3'd0) $display("[TB] FAIL reset_fill: got %0d expected 0", fill_count); else n_pass++;
    n_checks++;
    if (data_out !== 8'h00) $display("[TB] FAIL reset_data_out: got %h expected 00", data_out); else n_pass++;
    #10;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    hs_if.data_in    = 8'h5A;
    hs_if.data_valid = 1'b1;
    n_checks++;
    if (hs_if.data_ready !== 1'b0) $display("[TB] FAIL single_ready_pre: got %b expected 0", hs_if.data_ready); else n_pass++;
    tick();
    n_checks++;
    if (hs_if.data_ready !== 1'b1) $display("[TB] FAIL single_ready_rise: got %b expected 1", hs_if.data_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1) $display("[TB] FAIL single_out_valid: got %b expected 1", out_valid); else n_pass++;
    n_checks++;
    if (data_out !== 8'h5A) $display("[TB] FAIL single_data_out: got %h expected 5a", data_out); else n_pass++;
    n_checks++;
    if (fill_count !== 3'd1) $display("[TB] FAIL single_fill: got %0d expected 1", fill_count); else n_pass++;
    hs_if.data_valid = 1'b0;
    tick();
    n_checks++;
    if (hs_if.data_ready !== 1'b0) $display("[TB] FAIL single_ready_fall: got %b expected 0", hs_if.data_ready); else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fill_count !== 3'd0)
      $display("[TB] FAIL single_pop: got out_valid=%b fill=%0d expected 0/0", out_valid, fill_count);
    else n_pass++;
  endtask

  task automatic test_burst_full();
    bit ok;
    for (int i = 1; i <= 4; i++) begin
      send_word(8'(i), ok);
      n_checks++;
      if (!ok) $display("[TB] FAIL burst_ack_%0d: got no handshake expected ack", i); else n_pass++;
    end
    n_checks++;
    if (fill_count !== 3'd4) $display("[TB] FAIL burst_fill: got %0d expected 4", fill_count); else n_pass++;
    hs_if.data_in    = 8'h05;
    hs_if.data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (hs_if.data_ready !== 1'b0 || fill_count !== 3'd4)
        $display("[TB] FAIL full_hold_%0d: got ready=%b fill=%0d expected 0/4", i, hs_if.data_ready, fill_count);
      else n_pass++;
    end
    n_checks++;
    if (data_out !== 8'h01) $display("[TB] FAIL full_head: got %h expected 01", data_out); else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (hs_if.data_ready !== 1'b0 || fill_count !== 3'd3 || data_out !== 8'h02)
      $display("[TB] FAIL full_pop_edge: got ready=%b fill=%0d head=%h expected 0/3/02", hs_if.data_ready, fill_count, data_out);
    else n_pass++;
    tick();
    n_checks++;
    if (hs_if.data_ready !== 1'b1 || fill_count !== 3'd4)
      $display("[TB] FAIL full_accept_next: got ready=%b fill=%0d expected 1/4", hs_if.data_ready, fill_count);
    else n_pass++;
    hs_if.data_valid = 1'b0;
    tick();
    n_checks++;
    if (hs_if.data_ready !== 1'b0) $display("[TB] FAIL full_release: got %b expected 0", hs_if.data_ready); else n_pass++;
  endtask

  task automatic test_drain();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h02;
    exp_seq[1] = 8'h03;
    exp_seq[2] = 8'h04;
    exp_seq[3] = 8'h05;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || data_out !== exp_seq[i])
        $display("[TB] FAIL drain_%0d: got valid=%b data=%h expected 1/%h", i, out_valid, data_out, exp_seq[i]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || fill_count !== 3'd0)
      $display("[TB] FAIL drain_empty: got valid=%b fill=%0d expected 0/0", out_valid, fill_count);
    else n_pass++;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fill_count !== 3'd0)
      $display("[TB] FAIL drain_extra_pop: got valid=%b fill=%0d expected 0/0", out_valid, fill_count);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit ok;
    bit ok2;
    send_word(8'h11, ok);
    send_word(8'h22, ok2);
    n_checks++;
    if (!ok || !ok2 || fill_count !== 3'd2 || data_out !== 8'h11)
      $display("[TB] FAIL simul_setup: got fill=%0d head=%h expected 2/11", fill_count, data_out);
    else n_pass++;
    hs_if.data_in    = 8'hA5;
    hs_if.data_valid = 1'b1;
    rd_en            = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (fill_count !== 3'd2 || data_out !== 8'h22 || out_valid !== 1'b1 || hs_if.data_ready !== 1'b1)
      $display("[TB] FAIL simul_edge: got fill=%0d head=%h valid=%b ready=%b expected 2/22/1/1",
               fill_count, data_out, out_valid, hs_if.data_ready);
    else n_pass++;
    hs_if.data_valid = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    n_checks++;
    if (data_out !== 8'hA5 || fill_count !== 3'd1)
      $display("[TB] FAIL simul_last: got head=%h fill=%0d expected a5/1", data_out, fill_count);
    else n_pass++;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL simul_empty: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_held_request();
    hs_if.data_in    = 8'h3C;
    hs_if.data_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (fill_count !== 3'd1 || hs_if.data_ready !== 1'b1)
      $display("[TB] FAIL held_single_write: got fill=%0d ready=%b expected 1/1", fill_count, hs_if.data_ready);
    else n_pass++;
    hs_if.data_valid = 1'b0;
    tick();
    n_checks++;
    if (fill_count !== 3'd1 || data_out !== 8'h3C || hs_if.data_ready !== 1'b0)
      $display("[TB] FAIL held_release: got fill=%0d head=%h ready=%b expected 1/3c/0", fill_count, data_out, hs_if.data_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_handshake();
    bit ok;
    send_word(8'h66, ok);
    hs_if.data_in    = 8'h77;
    hs_if.data_valid = 1'b1;
    tick();
    n_checks++;
    if (!ok || hs_if.data_ready !== 1'b1 || fill_count !== 3'd3)
      $display("[TB] FAIL midrst_setup: got ready=%b fill=%0d expected 1/3", hs_if.data_ready, fill_count);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (hs_if.data_ready !== 1'b0 || out_valid !== 1'b0 || fill_count !== 3'd0)
      $display("[TB] FAIL midrst_async: got ready=%b valid=%b fill=%0d expected 0/0/0",
               hs_if.data_ready, out_valid, fill_count);
    else n_pass++;
    #3;
    rst = 1'b1;
    tick();
    n_checks++;
    if (hs_if.data_ready !== 1'b1 || fill_count !== 3'd1 || data_out !== 8'h77)
      $display("[TB] FAIL midrst_reaccept: got ready=%b fill=%0d head=%h expected 1/1/77",
               hs_if.data_ready, fill_count, data_out);
    else n_pass++;
    hs_if.data_valid = 1'b0;
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single_word();
    test_burst_full();
    test_drain();
    test_simultaneous();
    test_held_request();
    test_reset_mid_handshake();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
